bin2bcd_seq: RTL and testbench

- Sequential shift-add-3 (double-dabble) binary-to-BCD converter placed directly downstream of the 8-bit adder.
- Converts the 9-bit {carry, sum} result into packed BCD digits for the FND display path.
- Takes one cycle per input bit; uses a start/busy/done handshake.
- Holds the last converted result stable for the display scanner between conversions.

---
 rtl/calc_pkg.sv | 31 +++
 rtl/bcd_digit_adjust.sv | 19 +
 rtl/bin2bcd_seq.sv | 134 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator datapath blocks: BCD digit width,
// the double-dabble adjust constants, the converter FSM state encoding and a
// helper that checks whether a BCD field is wide enough for a binary input.
// No ports (package).
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int BCD_W      = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_t;

    // True when 10^digits > 2^in_w, i.e. every in_w-bit value fits in the
    // given number of decimal digits.
    function automatic bit bcd_fits(input int in_w, input int digits);
        longint p10;
        longint p2;
        p10 = 1;
        p2  = 1;
        for (int i = 0; i < digits; i++) p10 = p10 * 10;
        for (int i = 0; i < in_w; i++)   p2  = p2 * 2;
        return p10 > p2;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Combinational double-dabble correction for one BCD digit: adds 3 when the
// digit is 5 or more so that the following left shift carries correctly into
// the next decimal digit. The sum is truncated to 4 bits.
// Ports:
//   din   in   BCD_W  scratch digit before the shift
//   dout  out  BCD_W  corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adjust
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    assign dout = (din >= BCD_W'(ADJ_THRESH)) ? din + BCD_W'(ADJ_ADD) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-add-3 binary-to-BCD converter that sits behind the 8-bit
// adder and feeds the FND display path. One input bit is consumed per clock;
// the last result is held on bcd between conversions.
// Ports:
//   clk    in   1         system clock, rising edge
//   reset  in   1         synchronous, active-high reset
//   start  in   1         request a conversion (honoured only when idle)
//   bin    in   IN_W      binary value, captured on the accepted start edge
//   busy   out  1         conversion in progress
//   done   out  1         one-cycle pulse, bcd has just been updated
//   bcd    out  4*DIGITS  packed result, digit 0 (ones) in bits [3:0]
//   blank  out  DIGITS    leading-zero mask (only with BIN2BCD_BLANK_EN)
// Build option:
//   BIN2BCD_BLANK_EN  adds the registered blank output.
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int IN_W   = 9,
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [IN_W-1:0]         bin,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]       blank
`endif
);

    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int BCD_TOT = BCD_W * DIGITS;

    // An undersized digit field would silently wrap, so refuse to elaborate.
    if (!bcd_fits(IN_W, DIGITS)) begin : g_width_check
        $error("bin2bcd_seq: DIGITS too small for IN_W");
    end

    conv_state_t          state;
    logic [IN_W-1:0]      shreg;
    logic [BCD_TOT-1:0]   scratch;
    logic [CNT_W-1:0]     cnt;

    logic [BCD_TOT-1:0]      adjusted;
    logic [BCD_TOT+IN_W-1:0] shifted;
    logic [BCD_TOT-1:0]      next_scratch;
    logic [IN_W-1:0]         next_shreg;

    // One add-3 corrector per digit; all digits are corrected in parallel
    // before the combined register shifts.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .din  (scratch[BCD_W*i +: BCD_W]),
            .dout (adjusted[BCD_W*i +: BCD_W])
        );
    end

    // The MSB of the corrected scratch falls off the top; it is always zero
    // when the digit field is wide enough.
    assign shifted      = {adjusted, shreg} << 1;
    assign next_scratch = shifted[BCD_TOT+IN_W-1:IN_W];
    assign next_shreg   = shifted[IN_W-1:0];

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              higher_zero;

    // Walk from the most significant digit down; a digit is blanked while it
    // and everything above it is zero. The ones digit always shows.
    always_comb begin
        blank_next  = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            higher_zero   = higher_zero && (next_scratch[BCD_W*i +: BCD_W] == '0);
            blank_next[i] = higher_zero;
        end
        blank_next[0] = 1'b0;
    end
`else
    // No leading-zero mask in this build.
`endif

    // Control FSM and datapath registers. bcd is only written on the final
    // shift so the display never sees a partial result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
`ifdef BIN2BCD_BLANK_EN
            blank   <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        cnt     <= CNT_W'(IN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= next_scratch;
                    shreg   <= next_shreg;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bcd   <= next_scratch;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef BIN2BCD_BLANK_EN
                        blank <= blank_next;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq. Expected results are pushed to a queue
// when a start is accepted and popped when the DUT pulses done.
// Honours BIN2BCD_BLANK_EN to also check the blank output.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    localparam int IN_W   = 9;
    localparam int DIGITS = 4;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  blank;
        int          done_cycle;
        int          value;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
`ifdef BIN2BCD_BLANK_EN
    logic [3:0]  blank;
`endif

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   cycle;
    int   done_count;
    int   expected_dones;

    bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle++;

    // Decimal reference built with division, independent of double-dabble.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic logic [3:0] blank_of(input int v);
        logic [3:0] m;
        m[3] = (v < 1000);
        m[2] = (v < 100);
        m[1] = (v < 10);
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Called away from the rising edge; returns at the falling edge after the
    // edge that sampled start.
    task automatic applyStimulus(input int value, input bit expect_accept);
        exp_t e;
        bin   = 9'(value);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput(expect_accept ? "busy_after_start" : "busy_ignored_start", 32'(busy), 32'd1);
        if (expect_accept) begin
            e.bcd        = to_bcd(value);
            e.blank      = blank_of(value);
            e.done_cycle = cycle + IN_W;
            e.value      = value;
            exp_q.push_back(e);
            expected_dones++;
        end
    endtask

    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding start.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            bit   bad_digit;
            done_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("bcd[%0d]", e.value), 32'(bcd), 32'(e.bcd));
                checkOutput($sformatf("latency[%0d]", e.value), 32'(cycle), 32'(e.done_cycle));
                checkOutput("busy_at_done", 32'(busy), 32'd0);
                bad_digit = 1'b0;
                for (int d = 0; d < DIGITS; d++)
                    if (bcd[4*d +: 4] > 4'd9) bad_digit = 1'b1;
                checkOutput("digit_range", 32'(bad_digit), 32'd0);
`ifdef BIN2BCD_BLANK_EN
                checkOutput($sformatf("blank[%0d]", e.value), 32'(blank), 32'(e.blank));
`endif
            end
        end
    end

    initial begin
        vectors        = 0;
        miscompares    = 0;
        cycle          = 0;
        done_count     = 0;
        expected_dones = 0;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_bcd", 32'(bcd), 32'd0);
`ifdef BIN2BCD_BLANK_EN
        checkOutput("reset_blank", 32'(blank), 32'b1110);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Zero and full-scale inputs
        applyStimulus(0, 1'b1);
        waitDone();
        applyStimulus(511, 1'b1);
        waitDone();

        // Back-to-back: second start issued in the done cycle
        applyStimulus(255, 1'b1);
        waitDone();
        applyStimulus(100, 1'b1);
        waitDone();

        // Start while busy is ignored, result held afterwards
        applyStimulus(37, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(400, 1'b0);
        waitDone();
        repeat (12) @(negedge clk);
        checkOutput("bcd_hold", 32'(bcd), 32'h0037);

        // Reset mid-conversion aborts without a done pulse
        applyStimulus(128, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        expected_dones--;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_bcd", 32'(bcd), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        repeat (12) @(negedge clk);
        applyStimulus(128, 1'b1);
        waitDone();

        // Full sweep, back-to-back
        for (int v = 0; v < 512; v++) begin
            applyStimulus(v, 1'b1);
            waitDone();
        end

        repeat (3) @(negedge clk);
        checkOutput("done_count", 32'(done_count), 32'(expected_dones));
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
